// File: rtl/hex_scan_pkg.sv
// hex_scan_pkg: shared segment table, blank pattern and load FSM states for hex_scan_ctrl.
package hex_scan_pkg;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };
    typedef enum logic {IDLE, PEND} state_t;
endpackage

// File: rtl/hex_seg_lut.sv
// hex_seg_lut: nibble to active-low a..g segment pattern (bit6 = a).
module hex_seg_lut
    import hex_scan_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    assign seg = SEG_TABLE[nib];
endmodule

// File: rtl/hex_scan_ctrl.sv
// hex_scan_ctrl: multiplexed hex display scanner with a frame-synchronous load handshake.
// Define HEX_SCAN_LZ_BLANK_EN to blank leading zero digits (digit 0 always shows).
module hex_scan_ctrl
    import hex_scan_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_valid,
    input  logic [4*DIGITS-1:0] load_data,
    output logic                load_ready,
    output logic [6:0]          seg,
    output logic [DIGITS-1:0]   an,
    output logic                frame_tick
);
    localparam int DW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(DIGITS);
    localparam logic [DW-1:0] DIV_LAST  = DW'(REFRESH_DIV - 1);
    localparam logic [DW-1:0] GUARD_END = DW'(GUARD);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
    logic [DW-1:0]          div;
    logic [IW-1:0]          idx;
    logic [DIGITS-1:0][3:0] disp;
    logic [DIGITS-1:0][3:0] pend;
    state_t                 state;
    logic                   wrap;
    logic                   boundary;
    logic                   show;
    logic [DIGITS-1:0]      blank;
    logic [6:0]             lut_seg;
    assign wrap     = div == DIV_LAST;
    assign boundary = wrap && idx == IDX_LAST;
`ifdef HEX_SCAN_LZ_BLANK_EN
    logic lz_run;
    // Walk down from the top digit; a digit blanks while everything above it is zero too.
    always_comb begin
        blank  = '0;
        lz_run = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            lz_run   = lz_run && disp[i] == 4'h0;
            blank[i] = lz_run;
        end
    end
`else
    assign blank = '0;
`endif
    assign show = div >= GUARD_END && !blank[idx];
    hex_seg_lut u_lut (
        .nib (disp[idx]),
        .seg (lut_seg)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            div        <= '0;
            idx        <= '0;
            disp       <= '0;
            pend       <= '0;
            state      <= IDLE;
            load_ready <= 1'b1;
            seg        <= SEG_BLANK;
            an         <= '1;
            frame_tick <= 1'b0;
        end else begin
            div        <= wrap ? '0 : div + 1'b1;
            idx        <= wrap ? (idx == IDX_LAST ? '0 : idx + 1'b1) : idx;
            frame_tick <= boundary;
            seg        <= show ? lut_seg : SEG_BLANK;
            an         <= show ? ~(DIGITS'(1) << idx) : '1;
            if (state == IDLE && load_valid && boundary) begin
                disp <= load_data;
            end else if (state == IDLE && load_valid) begin
                pend       <= load_data;
                state      <= PEND;
                load_ready <= 1'b0;
            end else if (state == PEND && boundary) begin
                disp       <= pend;
                state      <= IDLE;
                load_ready <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_hex_scan_ctrl.sv
// tb_hex_scan_ctrl: directed literal checks plus randomized loads/resets against a cycle-count model.
module tb_hex_scan_ctrl;
    localparam int D = 4;
    localparam int R = 4;
    localparam int G = 1;
    logic        clk;
    logic        rst;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_ready;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_tick;
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int t = 0;
    bit armed = 0;
    logic [15:0] disp_m, pend_m;
    bit          busy_m;
    logic [6:0]  e_seg;
    logic [3:0]  e_an;
    logic        e_ready, e_tick;
    logic [6:0] segtab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    hex_scan_ctrl #(.DIGITS(D), .REFRESH_DIV(R), .GUARD(G)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .seg        (seg),
        .an         (an),
        .frame_tick (frame_tick)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit lz_blank(input logic [15:0] w, input int k);
`ifdef HEX_SCAN_LZ_BLANK_EN
        return k > 0 && (w >> (4 * k)) == 16'h0;
`else
        return 0;
`endif
    endfunction

    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    // Model: divider and digit index are pure functions of cycles since reset release.
    always @(posedge clk) begin
        if (rst) begin
            armed = 1;
            t = 0;
            disp_m = 0;
            pend_m = 0;
            busy_m = 0;
            e_seg = 7'h7F;
            e_an = 4'hF;
            e_ready = 1;
            e_tick = 0;
        end else if (armed) begin
            int d, k;
            bit bnd, sh;
            d = t % R;
            k = (t / R) % D;
            bnd = (t % (R * D)) == R * D - 1;
            sh = d >= G && !lz_blank(disp_m, k);
            e_seg = sh ? segtab[(disp_m >> (4 * k)) & 16'hF] : 7'h7F;
            e_an = sh ? 4'(~(1 << k)) : 4'hF;
            e_tick = bnd;
            if (!busy_m && load_valid) begin
                if (bnd) disp_m = load_data;
                else begin
                    pend_m = load_data;
                    busy_m = 1;
                end
            end else if (busy_m && bnd) begin
                disp_m = pend_m;
                busy_m = 0;
            end
            e_ready = !busy_m;
            t++;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("seg", 16'(seg), 16'(e_seg));
            chk("an", 16'(an), 16'(e_an));
            chk("load_ready", 16'(load_ready), 16'(e_ready));
            chk("frame_tick", 16'(frame_tick), 16'(e_tick));
        end
    end

    task automatic to_cyc(input int n);
        for (int i = 0; i < 200 && cyc != n; i++) @(negedge clk);
        if (cyc != n) chk("timeout_cyc", 16'(cyc), 16'(n));
    endtask

    initial begin
        rst = 1;
        load_valid = 0;
        load_data = 0;
        repeat (3) @(negedge clk);
        chk("rst_seg", 16'(seg), 16'h7F);
        chk("rst_an", 16'(an), 16'hF);
        chk("rst_ready", 16'(load_ready), 16'h1);
        chk("rst_tick", 16'(frame_tick), 16'h0);
        rst = 0;
        load_valid = 1;
        load_data = 16'h1234;
        to_cyc(1);
        load_valid = 0;
        chk("pend_ready", 16'(load_ready), 16'h0);
        chk("first_slot_guard_an", 16'(an), 16'hF);
        to_cyc(16);
        chk("commit_ready", 16'(load_ready), 16'h1);
        chk("commit_tick", 16'(frame_tick), 16'h1);
        to_cyc(17);
        chk("d0_guard_an", 16'(an), 16'hF);
        to_cyc(18);
        chk("d0_an", 16'(an), 16'b1110);
        chk("d0_seg", 16'(seg), 16'b1001100);
        to_cyc(29);
        chk("d3_guard_an", 16'(an), 16'hF);
        to_cyc(30);
        chk("d3_an", 16'(an), 16'b0111);
        chk("d3_seg", 16'(seg), 16'b1001111);
        to_cyc(31);
        load_valid = 1;
        load_data = 16'hABCD;
        to_cyc(32);
        load_valid = 0;
        chk("bnd_load_ready", 16'(load_ready), 16'h1);
        chk("bnd_tick", 16'(frame_tick), 16'h1);
        to_cyc(34);
        chk("bnd_d0_an", 16'(an), 16'b1110);
        chk("bnd_d0_seg", 16'(seg), 16'b1000010);
        for (int i = 0; i < 3000; i++) begin
            rst = $urandom_range(0, 249) == 0;
            load_valid = $urandom_range(0, 3) == 0;
            load_data = 16'($urandom);
            if ($urandom_range(0, 3) == 0) load_data = load_data & 16'h00FF;
            @(negedge clk);
        end
        rst = 0;
        load_valid = 0;
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/hex_scan_ctrl.md
HEX_SCAN_CTRL -- requirements
Module: hex_scan_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of multiplexed hex digits (2..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 50000: clock cycles per digit slot (>= 4).
REQ-003 SHALL have parameter GUARD, default 8: blanking cycles at the start of each slot (0 <= GUARD < REFRESH_DIV).
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk  in  1  system clock, rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 load_valid  in  1  new display word offered.
REQ-007 load_data  in  4*DIGITS  nibble i drives digit i; digit 0 = bits [3:0].
REQ-008 load_ready  out  1  block can accept load_data.
REQ-009 seg  out  7  active-low segments, bit6 = a ... bit0 = g.
REQ-010 an  out  DIGITS  active-low digit enables, one-hot-low or all ones.
REQ-011 frame_tick  out  1  one-cycle pulse when digit index wraps to 0.

Function
REQ-012 Divider counts 0..REFRESH_DIV-1 and wraps; digit index advances on the wrap cycle, DIGITS-1 -> 0.
REQ-013 Frame boundary is the cycle where the divider wraps and the index is DIGITS-1; frame_tick is high in the following cycle.
REQ-014 seg/an are registered: they reflect the current index and divider with 1-cycle latency.
REQ-015 While divider < GUARD: an all ones, seg 7'h7F (anti-ghosting); otherwise an[idx]=0, all others 1.
REQ-016 Decoding, 0..F: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100, 0001000, 1100000, 0110001, 1000010, 0110000, 0111000.
REQ-017 Handshake: a transfer occurs when load_valid && load_ready; load_data is captured into a pending register.
REQ-018 FSM: IDLE (load_ready=1) -> PEND on transfer; PEND (load_ready=0) -> IDLE on frame boundary, copying pending into the display register.
REQ-019 A transfer on a frame-boundary cycle in IDLE loads the display register directly and the FSM stays IDLE.
REQ-020 The display register changes only at frame boundaries, so no frame shows mixed old/new digits.
REQ-021 load_valid is ignored while load_ready=0; load_data is don't-care when load_valid=0.

Reset
REQ-022 On rst (sampled high at clk), the next cycle SHALL show: seg=7'h7F, an all ones, load_ready=1, frame_tick=0, divider=0, index=0, display and pending registers 0, FSM IDLE.
REQ-023 rst mid-frame or in PEND SHALL discard pending data; there is no partial commit.
REQ-024 After rst release, digit 0 is the first slot scanned.

Configuration
REQ-025 Macro HEX_SCAN_LZ_BLANK_EN SHALL select leading-zero blanking.
REQ-026 With the macro defined: a zero digit above the most significant non-zero digit is blanked (an bit stays 1, seg 7'h7F); digit 0 always shows.
REQ-027 Without the macro: every digit is always shown, including zeros.

Structure
REQ-028 A shared package hex_scan_pkg SHALL hold the 16-entry segment constant table, the SEG_BLANK constant (7'h7F) and the FSM state enum.
REQ-029 A combinational sub-module hex_seg_lut (4-bit in, 7-bit out) SHALL implement REQ-016 and be instantiated once, time-shared across digits.

Verification (DIGITS=4, REFRESH_DIV=4, GUARD=1)
REQ-030 Reset release, load 16'h1234 -> digit 0 slot: an=1110, seg=1001100 (4); digit 3 slot: an=0111, seg=1001111 (1); each slot starts with one cycle of an=1111.
REQ-031 Load 16'hABCD mid-frame -> load_ready=0 until the frame boundary; the next frame shows D, C, B, A; load_ready returns to 1; no mixed frame.
REQ-032 Second load_valid while in PEND -> ignored; the pending value remains the first word.
REQ-033 Load coinciding with the boundary cycle -> the new word shows in the very next frame; load_ready never drops.
REQ-034 rst asserted in PEND -> outputs match REQ-022; the display shows 0000 after reset (or only digit 0 with HEX_SCAN_LZ_BLANK_EN defined).
REQ-035 HEX_SCAN_LZ_BLANK_EN defined, load 16'h0050 -> digits 3 and 2 blank (an never 0 in those slots); digit 1 shows 5, digit 0 shows 0.
